immenc: RTL

Immediate encoder for the instruction-assembly path: the inverse of the immediate generator. It takes a 32-bit immediate, a format select and a 25-bit base field (instr[31:7] with register/funct bits already placed). It scatters the immediate bits into their format positions, merges them over the base, and flags immediates the format cannot represent. It is a two-stage valid/ready pipeline used by the self-test instruction patcher and the debug loader.

---
 rtl/imm_pkg.sv | 32 +++
 rtl/immenc_pack.sv | 78 +++++++
 rtl/immenc.sv | 98 +++++++++
 3 files changed

// File: rtl/imm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imm_pkg : immediate format selects and per-format instr[31:7] masks,     |
// |           shared by the immediate encoder and generator.  Rev 1.0       |
// +--------------------------------------------------------------------------+
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_sel_e;

  // Masks are expressed over instr[31:7], so bit 0 here is instr[7].
  localparam logic [24:0] MASK_I  = 25'h1FFE000;
  localparam logic [24:0] MASK_SB = 25'h1FC001F;
  localparam logic [24:0] MASK_UJ = 25'h1FFFFE0;

  // True when v[31:lsb] is not a pure sign extension.
  function automatic logic sext_bad(input logic [31:0] v, input int unsigned lsb);
    logic [31:0] hi;
    logic [31:0] ones;
    hi   = v >> lsb;
    ones = 32'hFFFF_FFFF >> lsb;
    return (hi != 32'd0) && (hi != ones);
  endfunction

endpackage
`default_nettype wire

// File: rtl/immenc_pack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | immenc_pack : combinational immediate scatter, base merge and range      |
// |               check (check built only with IMMENC_CHECK_EN).  Rev 1.0    |
// +--------------------------------------------------------------------------+
module immenc_pack
  import imm_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [31:0] imm,
  input  logic [24:0] base,
  output logic [24:0] data,
  output logic        err
);

  logic [24:0] place;
  logic [24:0] mask;

  always_comb begin
    place = '0;
    mask  = '0;
    case (imm_sel_e'(sel))
      IMM_I: begin
        place[24:13] = imm[11:0];
        mask         = MASK_I;
      end
      IMM_S: begin
        place[24:18] = imm[11:5];
        place[4:0]   = imm[4:0];
        mask         = MASK_SB;
      end
      IMM_B: begin
        place[24]    = imm[12];
        place[0]     = imm[11];
        place[23:18] = imm[10:5];
        place[4:1]   = imm[4:1];
        mask         = MASK_SB;
      end
      IMM_U: begin
        place[24:5]  = imm[31:12];
        mask         = MASK_UJ;
      end
      IMM_J: begin
        place[24]    = imm[20];
        place[12:5]  = imm[19:12];
        place[13]    = imm[11];
        place[23:14] = imm[10:1];
        mask         = MASK_UJ;
      end
      default: ;
    endcase
  end

  // An empty mask on an illegal select passes the base through untouched.
  assign data = (base & ~mask) | place;

`ifdef IMMENC_CHECK_EN
  logic bad;

  always_comb begin
    bad = 1'b1;
    case (imm_sel_e'(sel))
      IMM_I:   bad = sext_bad(imm, 11);
      IMM_S:   bad = sext_bad(imm, 11);
      IMM_B:   bad = imm[0] | sext_bad(imm, 12);
      IMM_U:   bad = |imm[11:0];
      IMM_J:   bad = imm[0] | sext_bad(imm, 20);
      default: bad = 1'b1;
    endcase
  end

  assign err = bad;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/immenc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | immenc : two-stage valid/ready immediate encoder with saturating error   |
// |          counter; checks/counter built with IMMENC_CHECK_EN.  Rev 1.0    |
// +--------------------------------------------------------------------------+
module immenc
  import imm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [2:0]       i_imm_sel,
  input  logic [31:0]      i_imm,
  input  logic [24:0]      i_base,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [24:0]      o_data,
  output logic             o_err,
  output logic             o_valid,
  input  logic             i_ready,
  input  logic             i_err_clr,
  output logic [CNT_W-1:0] o_err_cnt
);

  logic [24:0] enc_data;
  logic        enc_err;

  logic        s1_valid;
  logic [24:0] s1_data;
  logic        s1_err;

  logic        handoff;
  logic        s2_load;
  logic        s1_move;
  logic        accept;

  immenc_pack u_pack (
    .sel  (i_imm_sel),
    .imm  (i_imm),
    .base (i_base),
    .data (enc_data),
    .err  (enc_err)
  );

  assign handoff = o_valid & i_ready;
  assign s2_load = !o_valid | handoff;
  assign s1_move = s1_valid & s2_load;
  assign o_ready = !s1_valid | s1_move;
  assign accept  = i_valid & o_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_err   <= 1'b0;
    end else if (o_ready) begin
      s1_valid <= i_valid;
      if (accept) begin
        s1_data <= enc_data;
        s1_err  <= enc_err;
      end
    end
  end

  // Output data only changes on a real S1->S2 move, keeping it stable while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_err   <= 1'b0;
    end else if (s2_load) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_data <= s1_data;
        o_err  <= s1_err;
      end
    end
  end

`ifdef IMMENC_CHECK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_cnt <= '0;
    end else if (i_err_clr) begin
      o_err_cnt <= '0;
    end else if (handoff && o_err && !(&o_err_cnt)) begin
      o_err_cnt <= o_err_cnt + 1'b1;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = i_err_clr;
  assign o_err_cnt      = '0;
`endif

endmodule
`default_nettype wire
